// File: rtl/pwm_relay_pkg.sv
// Shared types and unit-conversion helpers for the PWM channel relay.
package pwm_relay_pkg;

    // Committed relay mode.
    typedef enum logic [1:0] {
        S_RX   = 2'd0,
        S_FC   = 2'd1,
        S_LOST = 2'd2
    } mode_state_t;

    // Classification of one measured AUX pulse.
    typedef enum logic [1:0] {
        VALID_RX = 2'd0,
        VALID_FC = 2'd1,
        INVALID  = 2'd2
    } pulse_class_t;

    function automatic longint unsigned us_to_cycles(input longint unsigned clk_hz,
                                                     input longint unsigned us);
        return (clk_hz * us) / 64'd1_000_000;
    endfunction

    function automatic longint unsigned ms_to_cycles(input longint unsigned clk_hz,
                                                     input longint unsigned ms);
        return (clk_hz * ms) / 64'd1_000;
    endfunction

endpackage

// File: rtl/pulse_width_meter.sv
// Synchronises the AUX input and measures its high time in microseconds.
// Emits a one-cycle strobe together with the latched width on each falling edge.
module pulse_width_meter
    import pwm_relay_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        aux_i,
    output logic [15:0] width_o,
    output logic        strobe_o
);

    localparam longint unsigned DIV_RAW = us_to_cycles(64'(CLK_HZ), 64'd1);
    localparam int unsigned     DIV     = (DIV_RAW == 0) ? 1 : 32'(DIV_RAW);
    localparam int unsigned     PW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic [2:0]    sync_q;
    logic [1:0]    fill_q;
    logic          armed_q, armed_d;
    logic          meas_q, meas_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   width_q;
    logic          strobe_q;
    logic          tick, rise, fall;

    // A pulse already high when reset releases is never measured: measurement
    // arms only after the synchronised line has been seen low post-reset.
    always_comb begin
        tick    = (presc_q == PW'(DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        rise    = armed_q & sync_q[1] & ~sync_q[2];
        fall    = meas_q & ~sync_q[1] & sync_q[2];
        armed_d = armed_q | (fill_q[1] & ~sync_q[1]);

        meas_d = meas_q;
        if (rise)
            meas_d = 1'b1;
        else if (fall)
            meas_d = 1'b0;

        cnt_d = cnt_q;
        if (rise)
            cnt_d = tick ? 16'd1 : '0;
        else if (meas_q && sync_q[1] && tick && cnt_q != '1)
            cnt_d = cnt_q + 16'd1;
    end

    // Sync chain, prescaler, width counter and falling-edge latch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            fill_q   <= '0;
            armed_q  <= 1'b0;
            meas_q   <= 1'b0;
            presc_q  <= '0;
            cnt_q    <= '0;
            width_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], aux_i};
            fill_q   <= {fill_q[0], 1'b1};
            armed_q  <= armed_d;
            meas_q   <= meas_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            strobe_q <= fall;
            if (fall)
                width_q <= cnt_q;
        end
    end

    assign width_o  = width_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/pwm_channel_relay.sv
// N-channel PWM relay: routes each output from the receiver or the servo
// driver according to the debounced AUX channel, with loss-of-AUX failsafe.
module pwm_channel_relay
    import pwm_relay_pkg::*;
#(
    parameter int unsigned NUM_CH      = 6,
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned THRESH_US   = 1500,
    parameter int unsigned MIN_US      = 800,
    parameter int unsigned MAX_US      = 2200,
    parameter int unsigned HOLD_FRAMES = 3,
    parameter int unsigned TIMEOUT_MS  = 50,
    parameter int unsigned CNT_W       = 22
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NUM_CH-1:0] rx_in,
    input  logic [NUM_CH-1:0] sd_in,
    input  logic              aux_in,
    output logic [NUM_CH-1:0] ch_out,
    output logic              mode_fc,
    output logic              aux_lost,
    output logic [15:0]       aux_width
);

    localparam int unsigned      RUN_W       = $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(ms_to_cycles(64'(CLK_HZ), 64'(TIMEOUT_MS)));

    logic             meas_strobe;
    pulse_class_t     pclass;
    logic             valid;
    mode_state_t      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] to_q, to_d;
    logic             opposite;

    pulse_width_meter #(
        .CLK_HZ(CLK_HZ)
    ) u_meter (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .aux_i   (aux_in),
        .width_o (aux_width),
        .strobe_o(meas_strobe)
    );

    // Classify the most recently latched AUX width.
    always_comb begin
        if (aux_width < 16'(MIN_US) || aux_width > 16'(MAX_US))
            pclass = INVALID;
        else if (aux_width > 16'(THRESH_US))
            pclass = VALID_FC;
        else
            pclass = VALID_RX;
        valid = meas_strobe && (pclass != INVALID);
    end

    // Mode FSM: debounced mode changes, direct exit from failsafe, and a
    // timeout that a same-cycle valid pulse overrides.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        opposite = ((state_q == S_RX) && (pclass == VALID_FC)) ||
                   ((state_q == S_FC) && (pclass == VALID_RX));

        if (valid)
            to_d = '0;
        else if (to_q != '1)
            to_d = to_q + CNT_W'(1);
        else
            to_d = to_q;

        if (meas_strobe) begin
            case (state_q)
                S_LOST: begin
                    run_d = '0;
                    if (valid)
                        state_d = (pclass == VALID_FC) ? S_FC : S_RX;
                end
                default: begin
                    if (opposite) begin
                        if (run_q == RUN_W'(HOLD_FRAMES - 1)) begin
                            state_d = (state_q == S_RX) ? S_FC : S_RX;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
            endcase
        end

        if (!valid && to_d == TIMEOUT_CYC) begin
            state_d = S_LOST;
            run_d   = '0;
        end
    end

    // Mode FSM, debounce run counter and timeout counter registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_RX;
            run_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            to_q    <= to_d;
        end
    end

    assign mode_fc  = (state_q != S_RX);
    assign aux_lost = (state_q == S_LOST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0] rx_sync_q;
        logic [1:0] sd_sync_q;
        logic       sel_q;
        logic       out_q;

        // Sync both sources; the select only moves while both are low, so a
        // pulse in flight is always finished on the source that started it.
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                rx_sync_q <= '0;
                sd_sync_q <= '0;
                sel_q     <= 1'b0;
                out_q     <= 1'b0;
            end else begin
                rx_sync_q <= {rx_sync_q[0], rx_in[i]};
                sd_sync_q <= {sd_sync_q[0], sd_in[i]};
                if (!rx_sync_q[1] && !sd_sync_q[1])
                    sel_q <= mode_fc;
                out_q <= sel_q ? sd_sync_q[1] : rx_sync_q[1];
            end
        end

        assign ch_out[i] = out_q;
    end

endmodule

// File: tb/tb_pwm_channel_relay.sv
// Scoreboard bench for pwm_channel_relay: stimulus queues expected output
// changes with their cycle stamps, a monitor pops and compares on every change.
module tb_pwm_channel_relay;

    localparam int NCH = 6;

    logic           CLOCK_50 = 1'b0;
    logic           reset;
    logic [NCH-1:0] rx_in;
    logic [NCH-1:0] sd_in;
    logic           aux_in;
    logic [NCH-1:0] ch_out;
    logic           mode_fc;
    logic           aux_lost;
    logic [15:0]    aux_width;

    pwm_channel_relay #(
        .NUM_CH     (NCH),
        .CLK_HZ     (1_000_000),
        .THRESH_US  (1500),
        .MIN_US     (800),
        .MAX_US     (2200),
        .HOLD_FRAMES(3),
        .TIMEOUT_MS (20),
        .CNT_W      (22)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .rx_in    (rx_in),
        .sd_in    (sd_in),
        .aux_in   (aux_in),
        .ch_out   (ch_out),
        .mode_fc  (mode_fc),
        .aux_lost (aux_lost),
        .aux_width(aux_width)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [17:0] st;   // {aux_width, mode_fc, aux_lost}
        int          at;
    } st_ev_t;

    typedef struct {
        string          name;
        logic [NCH-1:0] v;
        int             at;
    } ch_ev_t;

    st_ev_t st_q[$];
    ch_ev_t ch_q[$];

    int n_total = 0;
    int n_pass  = 0;
    bit mon_en  = 1'b0;

    logic [17:0]    prev_st;
    logic [NCH-1:0] prev_ch;

    task automatic tally(input bit ok, input string msg);
        n_total++;
        if (ok)
            n_pass++;
        else
            $display("FAIL %s", msg);
    endtask

    task automatic exp_st(input string name, input int w, input bit fc, input bit lost, input int at);
        st_ev_t e;
        e.name = name;
        e.st   = {16'(w), fc, lost};
        e.at   = at;
        st_q.push_back(e);
    endtask

    task automatic exp_ch(input string name, input logic [NCH-1:0] v, input int at);
        ch_ev_t e;
        e.name = name;
        e.v    = v;
        e.at   = at;
        ch_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Drive one AUX pulse of w cycles; returns the cycle stamp of the falling edge.
    task automatic aux_pulse(input int w, output int fall_at);
        aux_in = 1'b1;
        repeat (w) @(negedge CLOCK_50);
        aux_in  = 1'b0;
        fall_at = cyc;
    endtask

    // Monitor: every change of the status tuple or of ch_out must match the
    // next queued expectation, both in value and in cycle.
    always @(negedge CLOCK_50) begin : monitor
        logic [17:0] cur;
        st_ev_t      se;
        ch_ev_t      ce;
        cur = {aux_width, mode_fc, aux_lost};
        if (mon_en && cur !== prev_st) begin
            if (st_q.size() == 0) begin
                tally(1'b0, $sformatf("status_unexpected: got w=%0d fc=%b lost=%b at cycle %0d, expected no change",
                                      cur[17:2], cur[1], cur[0], cyc));
            end else begin
                se = st_q.pop_front();
                tally(cur === se.st && cyc == se.at,
                      $sformatf("%s: got w=%0d fc=%b lost=%b at cycle %0d, expected w=%0d fc=%b lost=%b at cycle %0d",
                                se.name, cur[17:2], cur[1], cur[0], cyc,
                                se.st[17:2], se.st[1], se.st[0], se.at));
            end
        end
        prev_st = cur;

        if (mon_en && ch_out !== prev_ch) begin
            if (ch_q.size() == 0) begin
                tally(1'b0, $sformatf("ch_unexpected: got ch_out=%b at cycle %0d, expected no change", ch_out, cyc));
            end else begin
                ce = ch_q.pop_front();
                tally(ch_out === ce.v && cyc == ce.at,
                      $sformatf("%s: got ch_out=%b at cycle %0d, expected %b at cycle %0d",
                                ce.name, ch_out, cyc, ce.v, ce.at));
            end
        end
        prev_ch = ch_out;
    end

    initial begin : watchdog
        #(10 * 120_000);
        $display("FAIL watchdog: got no completion within 120000 cycles, expected finish earlier");
        $fatal(1);
    end

    initial begin : stim
        int f;
        int f_last;

        reset  = 1'b1;
        aux_in = 1'b0;
        rx_in  = '0;
        sd_in  = '0;
        idle(3);
        tally(ch_out === '0 && mode_fc === 1'b0 && aux_lost === 1'b0 && aux_width === 16'd0,
              $sformatf("reset_state: got ch=%b fc=%b lost=%b w=%0d, expected 0 0 0 0",
                        ch_out, mode_fc, aux_lost, aux_width));
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(10);

        // Three FC pulses: width appears after the first, mode after the third.
        aux_pulse(1900, f); exp_st("t1_width", 1900, 1'b0, 1'b0, f + 3); idle(500);
        aux_pulse(1900, f); idle(500);
        aux_pulse(1900, f); exp_st("t1_mode_fc", 1900, 1'b1, 1'b0, f + 4); idle(500);

        // FC mode: an out-of-range pulse is ignored, three RX pulses return to RX.
        aux_pulse(2500, f); exp_st("t3_invalid_width", 2500, 1'b1, 1'b0, f + 3); idle(500);
        aux_pulse(1000, f); exp_st("t3_rx_width", 1000, 1'b1, 1'b0, f + 3); idle(500);
        aux_pulse(1000, f); idle(500);
        aux_pulse(1000, f); exp_st("t3_mode_rx", 1000, 1'b0, 1'b0, f + 4); idle(500);

        // RX mode: an RX pulse between FC pulses restarts the debounce.
        aux_pulse(1900, f); exp_st("t2_width_a", 1900, 1'b0, 1'b0, f + 3); idle(500);
        aux_pulse(1900, f); idle(500);
        aux_pulse(1000, f); exp_st("t2_width_b", 1000, 1'b0, 1'b0, f + 3); idle(500);
        aux_pulse(1900, f); exp_st("t2_width_c", 1900, 1'b0, 1'b0, f + 3); idle(500);
        aux_pulse(1900, f_last);

        // AUX silence: failsafe exactly TIMEOUT cycles after the last strobe is consumed.
        exp_st("timeout_lost", 1900, 1'b1, 1'b1, f_last + 4 + 20000);
        idle(20100);
        aux_pulse(1000, f);
        exp_st("lost_width", 1000, 1'b1, 1'b1, f + 3);
        exp_st("lost_exit_rx", 1000, 1'b0, 1'b0, f + 4);
        idle(500);

        // RX passthrough on channel 3 with 3-cycle latency.
        f = cyc;
        exp_ch("ch3_rise", 6'b001000, f + 3);
        exp_ch("ch3_fall", 6'b000000, f + 7);
        rx_in[3] = 1'b1; idle(4); rx_in[3] = 1'b0; idle(20);

        // Mode flips to FC while rx_in[0] is mid-pulse; sd_in[0] overlaps it.
        aux_pulse(1900, f); exp_st("sw_width", 1900, 1'b0, 1'b0, f + 3); idle(500);
        aux_pulse(1900, f); idle(500);
        aux_pulse(1900, f);
        exp_st("sw_mode_fc", 1900, 1'b1, 1'b0, f + 4);
        exp_ch("sw_rx_rise", 6'b000001, f + 3);
        exp_ch("sw_rx_fall", 6'b000000, f + 13);
        exp_ch("sw_sd_rise", 6'b000001, f + 23);
        exp_ch("sw_sd_fall", 6'b000000, f + 30);
        rx_in[0] = 1'b1;
        idle(2);  sd_in[0] = 1'b1;
        idle(4);  sd_in[0] = 1'b0;
        idle(4);  rx_in[0] = 1'b0;
        idle(10); sd_in[0] = 1'b1;
        idle(7);  sd_in[0] = 1'b0;
        idle(20);

        // Reset in the middle of an AUX pulse; its tail must not be measured.
        aux_in = 1'b1;
        idle(500);
        mon_en = 1'b0;
        reset  = 1'b1;
        idle(1);
        tally(ch_out === '0 && mode_fc === 1'b0 && aux_lost === 1'b0 && aux_width === 16'd0,
              $sformatf("midpulse_reset: got ch=%b fc=%b lost=%b w=%0d, expected 0 0 0 0",
                        ch_out, mode_fc, aux_lost, aux_width));
        reset = 1'b0;
        idle(1399);
        aux_in = 1'b0;
        idle(20);
        tally(aux_width === 16'd0 && mode_fc === 1'b0 && aux_lost === 1'b0,
              $sformatf("reset_tail_ignored: got w=%0d fc=%b lost=%b, expected 0 0 0",
                        aux_width, mode_fc, aux_lost));
        mon_en = 1'b1;
        idle(50);
        aux_pulse(1200, f); exp_st("fresh_width", 1200, 1'b0, 1'b0, f + 3);
        idle(50);

        tally(st_q.size() == 0 && ch_q.size() == 0,
              $sformatf("queues_drained: got %0d status and %0d channel events pending, expected 0 and 0",
                        st_q.size(), ch_q.size()));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
